// File: rtl/cmd_stream_assembler.sv
// cmd_stream_assembler
// Collects 4-byte little-endian host debug frames from a byte-wide AXI-Stream.
// Each good frame becomes one CMD_WIDTH-bit command word in a small FIFO.
// Commands are presented one at a time to the control FSM / datapath.
// Each command is held until cmd_done (or the optional hold timeout), then
// followed by a stretch of all-zero output so the control FSM returns to start.
//
// Output FSM states:
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_IDLE  | output zero; pop the FIFO head as soon as one is queued
//   ST_HOLD  | driving a command; wait for cmd_done or hold timeout
//   ST_CLEAR | output zero for CLEAR_CYCLES cycles; cmd_done ignored
module cmd_stream_assembler #(
    parameter int CMD_WIDTH    = 29,
    parameter int FIFO_DEPTH   = 4,
    parameter int HOLD_CYCLES  = 0,
    parameter int CLEAR_CYCLES = 1
) (
    input  logic                             CLOCK_50,
    input  logic                             rst,
    input  logic [7:0]                       s_TDATA,
    input  logic                             s_TVALID,
    input  logic                             s_TLAST,
    output logic                             s_TREADY,
    input  logic                             cmd_done,
    output logic [CMD_WIDTH-1:0]             cmd_out_TDATA,
    output logic                             cmd_active,
    output logic                             err_frame,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  pending_count
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int CLR_W  = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

    // Timers are down-counters: loaded with N-1 on entry, terminal count at zero.
    localparam logic [HOLD_W-1:0] HOLD_LOAD = (HOLD_CYCLES > 0) ? HOLD_W'(HOLD_CYCLES - 1) : '0;
    localparam logic [CLR_W-1:0]  CLR_LOAD  = CLR_W'(CLEAR_CYCLES - 1);
    localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_CLEAR
    } state_t;

    // Frame assembly state
    logic [1:0]               byte_idx;
    logic [23:0]              low_bytes;
    logic                     resync;
    logic [31:0]              frame_word;
    logic [31-CMD_WIDTH:0]    frame_excess;
    logic                     accept;
    logic                     push;

    // FIFO state
    logic [CMD_WIDTH-1:0]     fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;
    logic [CNT_W-1:0]         fifo_cnt;
    logic                     pop;

    // Output FSM state
    state_t                   state;
    logic [HOLD_W-1:0]        hold_cnt;
    logic [CLR_W-1:0]         clr_cnt;
    logic                     hold_expired;

    // Ready depends only on reset and the registered FIFO occupancy.
    assign s_TREADY      = !rst && (fifo_cnt < DEPTH_CNT);
    assign accept        = s_TVALID && s_TREADY;
    assign pending_count = fifo_cnt;

    // Byte 3 is never stored: it is combined with the three stored bytes at the
    // accepting edge so the command can be pushed on that same edge.
    assign frame_word    = {s_TDATA, low_bytes};
    assign frame_excess  = frame_word[31:CMD_WIDTH];
    assign push          = accept && !resync && (byte_idx == 2'd3) && s_TLAST
                           && (frame_excess == '0);

    assign pop           = (state == ST_IDLE) && (fifo_cnt != '0);
    assign hold_expired  = (HOLD_CYCLES > 0) && (hold_cnt == '0);

    // Frame assembly: byte index, partial word, framing errors and resync.
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            byte_idx  <= 2'd0;
            low_bytes <= '0;
            resync    <= 1'b0;
            err_frame <= 1'b0;
        end else begin
            err_frame <= 1'b0;
            if (accept) begin
                if (resync) begin
                    // Drop bytes until the lost frame's TLAST; no further errors.
                    if (s_TLAST) begin
                        resync <= 1'b0;
                    end
                end else if (byte_idx == 2'd3) begin
                    byte_idx <= 2'd0;
                    if (!s_TLAST) begin
                        err_frame <= 1'b1;
                        resync    <= 1'b1;
                    end else if (frame_excess != '0) begin
                        err_frame <= 1'b1;
                    end
                end else if (s_TLAST) begin
                    err_frame <= 1'b1;
                    byte_idx  <= 2'd0;
                end else begin
                    case (byte_idx)
                        2'd0:    low_bytes[7:0]   <= s_TDATA;
                        2'd1:    low_bytes[15:8]  <= s_TDATA;
                        default: low_bytes[23:16] <= s_TDATA;
                    endcase
                    byte_idx <= byte_idx + 2'd1;
                end
            end
        end
    end

    // Command FIFO; simultaneous push and pop leave the occupancy unchanged.
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= frame_word[CMD_WIDTH-1:0];
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Output FSM with registered command outputs and hold/clear timers.
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            state         <= ST_IDLE;
            cmd_out_TDATA <= '0;
            cmd_active    <= 1'b0;
            hold_cnt      <= '0;
            clr_cnt       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        cmd_out_TDATA <= fifo_mem[rd_ptr];
                        cmd_active    <= 1'b1;
                        hold_cnt      <= HOLD_LOAD;
                        state         <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // cmd_done and a timeout on the same edge give one CLEAR.
                    if (cmd_done || hold_expired) begin
                        cmd_out_TDATA <= '0;
                        cmd_active    <= 1'b0;
                        clr_cnt       <= CLR_LOAD;
                        state         <= ST_CLEAR;
                    end else if (hold_cnt != '0) begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (clr_cnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        clr_cnt <= clr_cnt - 1'b1;
                    end
                end
                default: begin
                    state         <= ST_IDLE;
                    cmd_out_TDATA <= '0;
                    cmd_active    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_stream_assembler.sv
// Bench for cmd_stream_assembler: instance a holds until cmd_done, instance b
// times out after 3 cycles. Expected commands go into per-instance queues when
// frames are driven and are popped by a monitor when cmd_active rises.
module tb_cmd_stream_assembler;

    localparam int CW = 29;

    logic          CLOCK_50 = 1'b0;
    logic          rst = 1'b1;

    logic [7:0]    a_data = 8'h00, b_data = 8'h00;
    logic          a_valid = 1'b0, a_last = 1'b0, a_done = 1'b0;
    logic          b_valid = 1'b0, b_last = 1'b0, b_done = 1'b0;
    logic          a_ready, b_ready, a_act, b_act, a_err, b_err;
    logic [CW-1:0] a_cmd, b_cmd;
    logic [2:0]    a_pend, b_pend;

    int            total = 0;
    int            bad = 0;

    logic [CW-1:0] exp_a [$];
    logic [CW-1:0] exp_b [$];
    logic [CW-1:0] a_exp_v, b_exp_v;

    always #10 CLOCK_50 = ~CLOCK_50;

    cmd_stream_assembler #(.CMD_WIDTH(CW), .FIFO_DEPTH(4), .HOLD_CYCLES(0), .CLEAR_CYCLES(1)) dut_a (
        .CLOCK_50      (CLOCK_50),
        .rst           (rst),
        .s_TDATA       (a_data),
        .s_TVALID      (a_valid),
        .s_TLAST       (a_last),
        .s_TREADY      (a_ready),
        .cmd_done      (a_done),
        .cmd_out_TDATA (a_cmd),
        .cmd_active    (a_act),
        .err_frame     (a_err),
        .pending_count (a_pend)
    );

    cmd_stream_assembler #(.CMD_WIDTH(CW), .FIFO_DEPTH(4), .HOLD_CYCLES(3), .CLEAR_CYCLES(1)) dut_b (
        .CLOCK_50      (CLOCK_50),
        .rst           (rst),
        .s_TDATA       (b_data),
        .s_TVALID      (b_valid),
        .s_TLAST       (b_last),
        .s_TREADY      (b_ready),
        .cmd_done      (b_done),
        .cmd_out_TDATA (b_cmd),
        .cmd_active    (b_act),
        .err_frame     (b_err),
        .pending_count (b_pend)
    );

    // Scoreboard monitor: value/order on each new command, zero output while
    // inactive, and at least CLEAR + IDLE zero cycles between commands.
    int   a_gap = 0, b_gap = 0;
    bit   a_seen = 0, b_seen = 0;
    logic a_prev = 1'b0, b_prev = 1'b0;

    always @(negedge CLOCK_50) begin
        if (rst) begin
            a_seen = 0; b_seen = 0; a_prev = 1'b0; b_prev = 1'b0; a_gap = 0; b_gap = 0;
        end else begin
            if (a_act && !a_prev) begin
                total++;
                if (exp_a.size() == 0) begin
                    bad++;
                    $display("FAIL sb_a_unexpected: got cmd=%h, required no command", a_cmd);
                end else begin
                    a_exp_v = exp_a.pop_front();
                    if (a_cmd !== a_exp_v) begin
                        bad++;
                        $display("FAIL sb_a_value: got cmd=%h, required %h", a_cmd, a_exp_v);
                    end
                end
                if (a_seen) begin
                    total++;
                    if (a_gap < 2) begin
                        bad++;
                        $display("FAIL sb_a_gap: got %0d zero cycles, required >=2", a_gap);
                    end
                end
                a_seen = 1; a_gap = 0;
            end else if (!a_act) begin
                a_gap++;
                total++;
                if (a_cmd !== '0) begin
                    bad++;
                    $display("FAIL a_idle_zero: got cmd=%h while inactive, required 0", a_cmd);
                end
            end
            a_prev = a_act;

            if (b_act && !b_prev) begin
                total++;
                if (exp_b.size() == 0) begin
                    bad++;
                    $display("FAIL sb_b_unexpected: got cmd=%h, required no command", b_cmd);
                end else begin
                    b_exp_v = exp_b.pop_front();
                    if (b_cmd !== b_exp_v) begin
                        bad++;
                        $display("FAIL sb_b_value: got cmd=%h, required %h", b_cmd, b_exp_v);
                    end
                end
                if (b_seen) begin
                    total++;
                    if (b_gap < 2) begin
                        bad++;
                        $display("FAIL sb_b_gap: got %0d zero cycles, required >=2", b_gap);
                    end
                end
                b_seen = 1; b_gap = 0;
            end else if (!b_act) begin
                b_gap++;
                total++;
                if (b_cmd !== '0) begin
                    bad++;
                    $display("FAIL b_idle_zero: got cmd=%h while inactive, required 0", b_cmd);
                end
            end
            b_prev = b_act;
        end
    end

    // Present one byte (from a negedge) and return at the negedge after it is accepted.
    task automatic send_byte(input bit sel, input logic [7:0] d, input logic l);
        int n = 0;
        if (sel) begin b_data = d; b_valid = 1'b1; b_last = l; end
        else     begin a_data = d; a_valid = 1'b1; a_last = l; end
        while (((sel) ? b_ready : a_ready) !== 1'b1 && n < 100) begin
            @(negedge CLOCK_50);
            n++;
        end
        total++;
        if (n >= 100) begin
            bad++;
            $display("FAIL send_byte_timeout: sel=%0d ready=0 for %0d cycles, required ready=1", sel, n);
        end
        @(negedge CLOCK_50);
        if (sel) begin b_valid = 1'b0; b_last = 1'b0; end
        else     begin a_valid = 1'b0; a_last = 1'b0; end
    endtask

    task automatic send_frame(input bit sel, input logic [31:0] w);
        send_byte(sel, w[7:0],   1'b0);
        send_byte(sel, w[15:8],  1'b0);
        send_byte(sel, w[23:16], 1'b0);
        send_byte(sel, w[31:24], 1'b1);
    endtask

    // Wait for a command to be driven, then pulse cmd_done for one cycle.
    task automatic wait_release(input bit sel);
        int n = 0;
        while (((sel) ? b_act : a_act) !== 1'b1 && n < 60) begin
            @(negedge CLOCK_50);
            n++;
        end
        total++;
        if (n >= 60) begin
            bad++;
            $display("FAIL release_wait: sel=%0d cmd_active=0 for %0d cycles, required 1", sel, n);
        end
        if (sel) b_done = 1'b1; else a_done = 1'b1;
        @(negedge CLOCK_50);
        a_done = 1'b0;
        b_done = 1'b0;
        @(negedge CLOCK_50);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge CLOCK_50);
        total++;
        if (a_cmd !== '0 || a_act !== 1'b0 || a_err !== 1'b0 || a_pend !== 3'd0 || a_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_a: got cmd=%h act=%b err=%b pend=%0d rdy=%b, required all 0",
                     a_cmd, a_act, a_err, a_pend, a_ready);
        end
        total++;
        if (b_cmd !== '0 || b_act !== 1'b0 || b_err !== 1'b0 || b_pend !== 3'd0 || b_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_b: got cmd=%h act=%b err=%b pend=%0d rdy=%b, required all 0",
                     b_cmd, b_act, b_err, b_pend, b_ready);
        end
        rst = 1'b0;
        @(negedge CLOCK_50);
        total++;
        if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_ready: got a=%b b=%b, required 1 1", a_ready, b_ready);
        end
    endtask

    task automatic test_pause();
        exp_a.push_back(29'h0000003);
        send_frame(1'b0, 32'h0000_0003);
        total++;
        if (a_pend !== 3'd1 || a_act !== 1'b0) begin
            bad++;
            $display("FAIL pause_queued: got pend=%0d act=%b, required pend=1 act=0", a_pend, a_act);
        end
        @(negedge CLOCK_50);
        total++;
        if (a_cmd !== 29'h0000003 || a_act !== 1'b1 || a_pend !== 3'd0) begin
            bad++;
            $display("FAIL pause_issue: got cmd=%h act=%b pend=%0d, required 0000003 1 0", a_cmd, a_act, a_pend);
        end
        repeat (19) @(negedge CLOCK_50);
        total++;
        if (a_cmd !== 29'h0000003 || a_act !== 1'b1) begin
            bad++;
            $display("FAIL pause_held: got cmd=%h act=%b, required 0000003 1", a_cmd, a_act);
        end
        a_done = 1'b1;
        @(negedge CLOCK_50);
        a_done = 1'b0;
        total++;
        if (a_cmd !== '0 || a_act !== 1'b0) begin
            bad++;
            $display("FAIL pause_release: got cmd=%h act=%b, required 0 0", a_cmd, a_act);
        end
        @(negedge CLOCK_50);
        total++;
        if (a_cmd !== '0 || a_act !== 1'b0) begin
            bad++;
            $display("FAIL pause_clear: got cmd=%h act=%b, required 0 0", a_cmd, a_act);
        end
    endtask

    task automatic test_done_ignored();
        a_done = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        a_done = 1'b0;
        exp_a.push_back(29'h000003C);
        send_frame(1'b0, 32'h0000_003C);
        repeat (6) @(negedge CLOCK_50);
        total++;
        if (a_cmd !== 29'h000003C || a_act !== 1'b1) begin
            bad++;
            $display("FAIL done_ignored_idle: got cmd=%h act=%b, required 000003c 1", a_cmd, a_act);
        end
        wait_release(1'b0);
    endtask

    task automatic test_timeout();
        int hi = 0;
        exp_b.push_back(29'h0000009);
        send_frame(1'b1, 32'h0000_0009);
        for (int i = 0; i < 10; i++) begin
            @(negedge CLOCK_50);
            if (b_act) hi++;
        end
        total++;
        if (hi != 3) begin
            bad++;
            $display("FAIL timeout_len: got %0d active cycles, required 3", hi);
        end
        total++;
        if (b_pend !== 3'd0 || b_cmd !== '0) begin
            bad++;
            $display("FAIL timeout_after: got pend=%0d cmd=%h, required 0 0", b_pend, b_cmd);
        end
    endtask

    task automatic test_done_with_timeout();
        exp_b.push_back(29'h000000A);
        exp_b.push_back(29'h000000B);
        send_frame(1'b1, 32'h0000_000A);
        fork
            send_frame(1'b1, 32'h0000_000B);
            begin
                repeat (3) @(negedge CLOCK_50);
                b_done = 1'b1;
                @(negedge CLOCK_50);
                b_done = 1'b0;
            end
        join
        total++;
        if (b_cmd !== '0 || b_act !== 1'b0 || b_pend !== 3'd1) begin
            bad++;
            $display("FAIL coincide_clear: got cmd=%h act=%b pend=%0d, required 0 0 1", b_cmd, b_act, b_pend);
        end
        repeat (2) @(negedge CLOCK_50);
        total++;
        if (b_cmd !== 29'h000000B || b_act !== 1'b1) begin
            bad++;
            $display("FAIL coincide_next: got cmd=%h act=%b, required 000000b 1", b_cmd, b_act);
        end
        repeat (6) @(negedge CLOCK_50);
    endtask

    task automatic test_framing();
        send_byte(1'b0, 8'h21, 1'b0);
        send_byte(1'b0, 8'h00, 1'b1);
        total++;
        if (a_err !== 1'b1) begin
            bad++;
            $display("FAIL frame_short_err: got err=%b, required 1", a_err);
        end
        @(negedge CLOCK_50);
        total++;
        if (a_err !== 1'b0 || a_pend !== 3'd0) begin
            bad++;
            $display("FAIL frame_short_pulse: got err=%b pend=%0d, required 0 0", a_err, a_pend);
        end
        send_byte(1'b0, 8'h01, 1'b0);
        send_byte(1'b0, 8'h02, 1'b0);
        send_byte(1'b0, 8'h03, 1'b0);
        send_byte(1'b0, 8'h04, 1'b0);
        total++;
        if (a_err !== 1'b1) begin
            bad++;
            $display("FAIL frame_long_err: got err=%b, required 1", a_err);
        end
        send_byte(1'b0, 8'h05, 1'b1);
        total++;
        if (a_err !== 1'b0 || a_pend !== 3'd0) begin
            bad++;
            $display("FAIL frame_long_single: got err=%b pend=%0d, required 0 0", a_err, a_pend);
        end
        send_frame(1'b0, 32'h2000_0001);
        total++;
        if (a_err !== 1'b1 || a_pend !== 3'd0) begin
            bad++;
            $display("FAIL frame_top_bits: got err=%b pend=%0d, required 1 0", a_err, a_pend);
        end
        @(negedge CLOCK_50);
        total++;
        if (a_err !== 1'b0 || a_act !== 1'b0 || a_cmd !== '0) begin
            bad++;
            $display("FAIL frame_top_quiet: got err=%b act=%b cmd=%h, required 0 0 0", a_err, a_act, a_cmd);
        end
        exp_a.push_back(29'h0000055);
        send_frame(1'b0, 32'h0000_0055);
        wait_release(1'b0);
    endtask

    task automatic test_backpressure();
        bit quiet = 1;
        int n = 0;
        for (int i = 1; i <= 6; i++) exp_a.push_back(CW'(i));
        for (int i = 1; i <= 5; i++) send_frame(1'b0, 32'(i));
        total++;
        if (a_pend !== 3'd4 || a_ready !== 1'b0 || a_cmd !== 29'h1) begin
            bad++;
            $display("FAIL bp_full: got pend=%0d rdy=%b cmd=%h, required 4 0 0000001", a_pend, a_ready, a_cmd);
        end
        fork
            send_frame(1'b0, 32'h0000_0006);
            begin
                repeat (5) begin
                    @(negedge CLOCK_50);
                    if (a_ready !== 1'b0 || a_pend !== 3'd4) quiet = 0;
                end
                total++;
                if (!quiet) begin
                    bad++;
                    $display("FAIL bp_stall: got rdy=%b pend=%0d during stall, required rdy=0 pend=4", a_ready, a_pend);
                end
                a_done = 1'b1;
                @(negedge CLOCK_50);
                a_done = 1'b0;
                while (a_ready !== 1'b1 && n < 20) begin
                    @(negedge CLOCK_50);
                    n++;
                end
                total++;
                if (a_ready !== 1'b1) begin
                    bad++;
                    $display("FAIL bp_ready_rise: got rdy=%b after %0d cycles, required 1", a_ready, n);
                end
            end
        join
        for (int i = 0; i < 5; i++) wait_release(1'b0);
    endtask

    task automatic test_reset_mid();
        exp_a.push_back(29'h0000007);
        send_frame(1'b0, 32'h0000_0007);
        @(negedge CLOCK_50);
        exp_a.push_back(29'h0000008);
        send_frame(1'b0, 32'h0000_0008);
        send_byte(1'b0, 8'hAA, 1'b0);
        send_byte(1'b0, 8'hBB, 1'b0);
        total++;
        if (a_act !== 1'b1 || a_pend !== 3'd1) begin
            bad++;
            $display("FAIL rst_mid_setup: got act=%b pend=%0d, required 1 1", a_act, a_pend);
        end
        rst = 1'b1;
        @(negedge CLOCK_50);
        total++;
        if (a_cmd !== '0 || a_act !== 1'b0 || a_pend !== 3'd0 || a_err !== 1'b0 || a_ready !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid: got cmd=%h act=%b pend=%0d err=%b rdy=%b, required all 0",
                     a_cmd, a_act, a_pend, a_err, a_ready);
        end
        exp_a.delete();
        exp_b.delete();
        rst = 1'b0;
        @(negedge CLOCK_50);
        exp_a.push_back(29'h0000011);
        send_frame(1'b0, 32'h0000_0011);
        @(negedge CLOCK_50);
        total++;
        if (a_cmd !== 29'h0000011 || a_act !== 1'b1) begin
            bad++;
            $display("FAIL rst_recover: got cmd=%h act=%b, required 0000011 1", a_cmd, a_act);
        end
        wait_release(1'b0);
    endtask

    initial begin
        test_reset();
        test_pause();
        test_done_ignored();
        test_timeout();
        test_done_with_timeout();
        test_framing();
        test_backpressure();
        test_reset_mid();
        repeat (4) @(negedge CLOCK_50);
        total++;
        if (exp_a.size() != 0 || exp_b.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: got %0d/%0d commands never issued, required 0/0", exp_a.size(), exp_b.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule

// File: doc/cmd_stream_assembler.md
Name: cmd_stream_assembler

Overview:
- Upstream feeder for control_FSM/datapath.
- Accepts a byte-wide AXI-Stream of host debug commands and assembles each 4-byte frame into a 29-bit command word.
- Queues commands in a small FIFO and drives one command at a time onto cmd_out_TDATA (the control path's cmd_in_TDATA).
- Holds each command until the governor reports completion or a hold timeout expires, then drives zero so the control FSM returns to its start state.

Parameters:
- CMD_WIDTH, 29: command word width, equal to the control-path cmd_in_TDATA width.
- FIFO_DEPTH, 4: queued commands, excluding the one being driven; power of two, ≥2.
- HOLD_CYCLES, 0: 0 holds each command until cmd_done; N>0 holds for at most N cycles.
- CLEAR_CYCLES, 1: cycles of all-zero command driven between commands; minimum 1.

Ports:
- CLOCK_50  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- s_TDATA  in  8  command byte, little-endian within the frame.
- s_TVALID  in  1  byte valid.
- s_TLAST  in  1  last byte of frame.
- s_TREADY  out  1  byte accepted when s_TVALID & s_TREADY.
- cmd_done  in  1  completion from the control path (OR of done_DONE_* signals).
- cmd_out_TDATA  out  CMD_WIDTH  command presented to control_FSM and datapath.
- cmd_active  out  1  high while cmd_out_TDATA carries a real command.
- err_frame  out  1  one-cycle pulse when a frame is discarded.
- pending_count  out  $clog2(FIFO_DEPTH+1)  queued commands.

Behaviour:
- Reset: all of the following are driven or cleared.
  - Outputs: cmd_out_TDATA=0, cmd_active=0, err_frame=0, pending_count=0, s_TREADY=0 during reset.
  - Internal: byte index=0, FIFO flushed, output FSM to IDLE, resync flag cleared.
  - Applies mid-frame and mid-hold; partial frames are discarded silently, with no err_frame.
- s_TREADY = !rst && (pending_count < FIFO_DEPTH). It is registered-state derived, with no combinational path from s_TVALID.
- Assembly:
  - A byte index 0..3 increments on each accepted byte; byte k fills bits [8k+7:8k] of a 32-bit shift word.
  - Good frame: TLAST on index 3 and word[31:29]==0. Push word[28:0] into the FIFO at the accepting edge and reset index to 0.
  - TLAST on index 0..2: discard, pulse err_frame the next cycle, reset index to 0.
  - Index 3 without TLAST: discard, pulse err_frame, set resync. While resync is set, accepted bytes are dropped until one with TLAST, which clears resync. No further err_frame pulses during resync.
  - Index 3 with TLAST but word[31:29]!=0: discard, pulse err_frame.
- FIFO:
  - Synchronous; push and pop may occur in the same cycle, leaving the count unchanged.
  - A push is never attempted when full, because s_TREADY guards it.
  - A pop from empty never occurs.
- Output FSM states:
  - IDLE: if FIFO is non-empty, pop and register cmd_out_TDATA<=head, cmd_active<=1, hold counter<=0, go to HOLD. Otherwise cmd_out_TDATA stays 0.
  - HOLD: counter increments each cycle.
    - If cmd_done is sampled high, go to CLEAR.
    - Otherwise, if HOLD_CYCLES>0 and counter==HOLD_CYCLES-1, go to CLEAR.
    - On entry to CLEAR, cmd_out_TDATA<=0 and cmd_active<=0 at that edge.
  - CLEAR: counter counts CLEAR_CYCLES cycles with output 0, then goes to IDLE. cmd_done is ignored.
- Latency:
  - A frame pushed at edge E appears on cmd_out_TDATA from edge E+1 if the FSM is in IDLE with an empty FIFO.
  - A pushed frame is never lost; it waits in the FIFO otherwise.
- Back-to-back commands are always separated by ≥CLEAR_CYCLES zero cycles plus one IDLE cycle.
- cmd_done is ignored outside HOLD. A cmd_done on the same edge that a HOLD timeout fires produces a single CLEAR.

Test Plan:
- Pause, HOLD_CYCLES=0: bytes 03,00,00,00 (TLAST on 4th); cmd_done raised 20 cycles later.
  - Required: cmd_out_TDATA=0x0000003 and cmd_active=1 from the edge after the 4th byte.
  - Required: 0 one cycle after cmd_done is sampled, and 0 for 1 CLEAR cycle.
- Timeout, HOLD_CYCLES=3: frame 09,00,00,00 with cmd_done held low.
  - Required: cmd_out_TDATA=0x0000009 for exactly 3 cycles, then 0; pending_count=0.
- Framing errors:
  - Frame 21,00 with TLAST on the 2nd byte → err_frame pulse, no command.
  - Five bytes without TLAST on byte 4, then TLAST on byte 5 → one err_frame pulse, no command.
  - Frame 01,00,00,20 (bit 29 set) → err_frame pulse, cmd_out stays 0.
- Backpressure, cmd_done low, HOLD_CYCLES=0: send 6 valid frames 01..06.
  - Required: frame 1 is driven, frames 2–5 are queued (pending_count=4), s_TREADY=0 during frame 6.
  - Required: after cmd_done, s_TREADY rises, and commands 2..6 issue in order, each separated by a 0 cycle.
- Reset mid-operation: assert rst after 2 bytes of a frame and during HOLD of an earlier command.
  - Required: next cycle cmd_out_TDATA=0, cmd_active=0, pending_count=0.
  - Required: a following clean frame 11,00,00,00 issues 0x0000011 normally.
